// File: rtl/freq_regulator_gen2.sv
// Ring-oscillator period regulator: measures ring_clk in reference cycles and nudges the divider into [fmax, fmin].
// Optional build macro FREQREG_AVG_EN averages four periods per decision.
module freq_regulator_gen2 #(
  parameter int W      = 8,
  parameter int SETTLE = 4,
  parameter int STEP   = 1
) (
  input  logic         clk_frequency,
  input  logic         rst_frequency,
  input  logic         init,
  input  logic         ring_clk,
  input  logic [W-1:0] setperiod,
  input  logic [W-1:0] fmin,
  input  logic [W-1:0] fmax,
  output logic [W-1:0] adjusteddiv,
  output logic         increment,
  output logic         decrement,
  output logic         co,
  output logic         locked,
  output logic [W-1:0] final_sett,
  output logic         sat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_DECIDE,
    S_LOCKED
  } state_t;

  localparam logic [W-1:0] PMAX     = {W{1'b1}};
  localparam logic [W:0]   STEP_X   = (W+1)'(STEP);
  localparam logic [3:0]   SETTLE_X = 4'(SETTLE);

  function automatic logic [W-1:0] p_inc_sat(input logic [W-1:0] v);
    return (v == PMAX) ? v : v + W'(1);
  endfunction

  // Bit W of the result flags overflow (add) or borrow (subtract).
  function automatic logic [W:0] div_up(input logic [W-1:0] v);
    return {1'b0, v} + STEP_X;
  endfunction

  function automatic logic [W:0] div_dn(input logic [W-1:0] v);
    return {1'b0, v} - STEP_X;
  endfunction

  state_t       state_q, state_d;
  logic         sync1_q, sync2_q, prev_q;
  logic         rise;
  logic [W-1:0] p_q, p_d;
  logic         to_q, to_d;
  logic [3:0]   lcnt_q, lcnt_d, lcnt_nx;
  logic [W-1:0] div_q, div_d;
  logic         inc_q, inc_d;
  logic         dec_q, dec_d;
  logic         co_q, co_d;
  logic         lock_q, lock_d;
  logic [W-1:0] fs_q, fs_d;
  logic         sat_q, sat_d;
  logic [W:0]   up_r, dn_r;
  logic [W-1:0] dval;
  logic         decide, too_slow, too_fast;

`ifdef FREQREG_AVG_EN
  logic [W+1:0] acc_q, acc_d, sum;
  logic [1:0]   grp_q, grp_d;
`endif

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    to_d     = to_q;
    lcnt_d   = lcnt_q;
    div_d    = div_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    co_d     = 1'b0;
    lock_d   = lock_q;
    fs_d     = fs_q;
    sat_d    = sat_q;
    up_r     = div_up(div_q);
    dn_r     = div_dn(div_q);
    lcnt_nx  = lcnt_q + 4'd1;
    dval     = '0;
    decide   = 1'b0;
    too_slow = 1'b0;
    too_fast = 1'b0;
`ifdef FREQREG_AVG_EN
    acc_d    = acc_q;
    grp_d    = grp_q;
    sum      = '0;
`endif
    if (!init) begin
      state_d = S_IDLE;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          div_d   = setperiod;
          lcnt_d  = '0;
          p_d     = '0;
          to_d    = 1'b0;
`ifdef FREQREG_AVG_EN
          acc_d   = '0;
          grp_d   = '0;
`endif
          state_d = S_ARM;
        end
        // ARM and LOCKED wait for the start edge; a dead ring times out here too.
        S_ARM, S_LOCKED: begin
          if (rise) begin
            p_d     = '0;
            state_d = S_MEASURE;
          end else begin
            p_d = p_inc_sat(p_q);
            if (p_q == PMAX) begin
              to_d    = 1'b1;
              co_d    = 1'b1;
              state_d = S_DECIDE;
            end
          end
        end
        S_MEASURE: begin
          p_d = p_inc_sat(p_q);
          if (rise || (p_q == PMAX)) begin
            to_d    = (p_q == PMAX);
            co_d    = 1'b1;
            state_d = S_DECIDE;
          end
        end
        S_DECIDE: begin
          p_d     = '0;
          state_d = lock_q ? S_LOCKED : S_ARM;
`ifdef FREQREG_AVG_EN
          sum = acc_q + {2'b00, p_q};
          if (to_q || (grp_q == 2'd3)) begin
            decide = 1'b1;
            dval   = W'(sum >> 2);
            acc_d  = '0;
            grp_d  = '0;
          end else begin
            acc_d  = sum;
            grp_d  = grp_q + 2'd1;
          end
`else
          decide = 1'b1;
          dval   = p_q;
`endif
          too_slow = to_q || (dval > fmin);
          too_fast = !too_slow && (dval < fmax);
          if (decide) begin
            if (too_slow || too_fast) begin
              lcnt_d  = '0;
              lock_d  = 1'b0;
              state_d = S_ARM;
              if (too_slow) begin
                if (dn_r[W]) begin
                  sat_d = 1'b1;
                end else begin
                  div_d = dn_r[W-1:0];
                  dec_d = 1'b1;
                  sat_d = 1'b0;
                end
              end else begin
                if (up_r[W]) begin
                  sat_d = 1'b1;
                end else begin
                  div_d = up_r[W-1:0];
                  inc_d = 1'b1;
                  sat_d = 1'b0;
                end
              end
            end else begin
              sat_d = 1'b0;
              if (!lock_q) begin
                lcnt_d = lcnt_nx;
                if (lcnt_nx == SETTLE_X) begin
                  lock_d  = 1'b1;
                  fs_d    = div_q;
                  state_d = S_LOCKED;
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_frequency or posedge rst_frequency) begin
    if (rst_frequency) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      p_q     <= '0;
      to_q    <= 1'b0;
      lcnt_q  <= '0;
      div_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      co_q    <= 1'b0;
      lock_q  <= 1'b0;
      fs_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= ring_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      p_q     <= p_d;
      to_q    <= to_d;
      lcnt_q  <= lcnt_d;
      div_q   <= div_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      co_q    <= co_d;
      lock_q  <= lock_d;
      fs_q    <= fs_d;
      sat_q   <= sat_d;
    end
  end

`ifdef FREQREG_AVG_EN
  always_ff @(posedge clk_frequency or posedge rst_frequency) begin
    if (rst_frequency) begin
      acc_q <= '0;
      grp_q <= '0;
    end else begin
      acc_q <= acc_d;
      grp_q <= grp_d;
    end
  end
`endif

  assign adjusteddiv = div_q;
  assign increment   = inc_q;
  assign decrement   = dec_q;
  assign co          = co_q;
  assign locked      = lock_q;
  assign final_sett  = fs_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_freq_regulator_gen2.sv
// Bench for freq_regulator_gen2: a programmable ring generator feeds the DUT and a
// decision-level model predicts every adjustment, lock and saturation outcome.
module tb_freq_regulator_gen2;
  localparam int W      = 8;
  localparam int SETTLE = 4;
  localparam int STEP   = 1;
  localparam int PMAXI  = 255;

  logic         clk_frequency = 1'b0;
  logic         rst_frequency;
  logic         init;
  logic         ring_clk;
  logic [W-1:0] setperiod, fmin, fmax;
  logic [W-1:0] adjusteddiv, final_sett;
  logic         increment, decrement, co, locked, sat;

  int tests = 0;
  int fails = 0;

  int per     = 200;
  int gen_req = 0;
  int gen_ack = 0;
  int cnt     = 0;
  int inc_seen = 0, dec_seen = 0, co_seen = 0;

  int m_div = 0, m_lcnt = 0, m_fs = 0, m_inc = 0, m_dec = 0;
  bit m_locked = 1'b0, m_sat = 1'b0;

  always #5 clk_frequency = ~clk_frequency;

  freq_regulator_gen2 #(.W(W), .SETTLE(SETTLE), .STEP(STEP)) dut (
    .clk_frequency(clk_frequency),
    .rst_frequency(rst_frequency),
    .init         (init),
    .ring_clk     (ring_clk),
    .setperiod    (setperiod),
    .fmin         (fmin),
    .fmax         (fmax),
    .adjusteddiv  (adjusteddiv),
    .increment    (increment),
    .decrement    (decrement),
    .co           (co),
    .locked       (locked),
    .final_sett   (final_sett),
    .sat          (sat)
  );

  function automatic int ring_next(input int c, input int p);
    return (c + 1 >= p) ? 0 : c + 1;
  endfunction

  // Rising edges every per cycles; a restart request parks the ring low; per==0 holds it low.
  always @(negedge clk_frequency) begin
    if (gen_req != gen_ack) begin
      gen_ack  <= gen_req;
      cnt      <= per / 2;
      ring_clk <= 1'b0;
    end else if (per == 0) begin
      cnt      <= 0;
      ring_clk <= 1'b0;
    end else begin
      cnt      <= ring_next(cnt, per);
      ring_clk <= (ring_next(cnt, per) < per / 2);
    end
  end

  always @(negedge clk_frequency) begin
    if (increment === 1'b1) inc_seen <= inc_seen + 1;
    if (decrement === 1'b1) dec_seen <= dec_seen + 1;
    if (co === 1'b1)        co_seen  <= co_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_load(input int sp);
    m_div    = sp;
    m_lcnt   = 0;
    m_locked = 1'b0;
  endtask

  // Waits for co, applies the window rules to the known ring period, checks the cycle after co.
  task automatic measure(input string tag, output int cyc);
    int p;
    bit slow, fast, e_inc, e_dec;
    cyc = 0;
    do begin
      @(posedge clk_frequency); #1;
      cyc++;
    end while (co !== 1'b1 && cyc < 1200);
    chk({tag, ".co"}, co, 1);
    p     = (per == 0) ? PMAXI : per;
    slow  = (per == 0) || (p > int'(fmin));
    fast  = !slow && (p < int'(fmax));
    e_inc = 1'b0;
    e_dec = 1'b0;
    if (slow || fast) begin
      m_lcnt   = 0;
      m_locked = 1'b0;
      if (slow) begin
        if (m_div - STEP < 0) m_sat = 1'b1;
        else begin m_div -= STEP; m_sat = 1'b0; e_dec = 1'b1; end
      end else begin
        if (m_div + STEP > PMAXI) m_sat = 1'b1;
        else begin m_div += STEP; m_sat = 1'b0; e_inc = 1'b1; end
      end
    end else begin
      m_sat = 1'b0;
      if (!m_locked) begin
        m_lcnt++;
        if (m_lcnt >= SETTLE) begin
          m_locked = 1'b1;
          m_fs     = m_div;
        end
      end
    end
    m_inc += int'(e_inc);
    m_dec += int'(e_dec);
    @(posedge clk_frequency); #1;
    chk({tag, ".co_pulse"}, co, 0);
    chk({tag, ".inc"}, increment, e_inc);
    chk({tag, ".dec"}, decrement, e_dec);
    chk({tag, ".div"}, adjusteddiv, m_div);
    chk({tag, ".locked"}, locked, m_locked);
    chk({tag, ".final_sett"}, final_sett, m_fs);
    chk({tag, ".sat"}, sat, m_sat);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".div"}, adjusteddiv, 0);
    chk({tag, ".final_sett"}, final_sett, 0);
    chk({tag, ".co"}, co, 0);
    chk({tag, ".inc"}, increment, 0);
    chk({tag, ".dec"}, decrement, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".sat"}, sat, 0);
  endtask

  initial begin
    int cyc, snap, held;
    rst_frequency = 1'b1;
    init          = 1'b0;
    setperiod     = '0;
    fmin          = 8'd160;
    fmax          = 8'd90;
    per           = 200;
    gen_req++;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk_frequency);
    #1 rst_frequency = 1'b0;

    // Load and the slow-ring decrements
    @(posedge clk_frequency); #1;
    setperiod = 8'd253;
    init      = 1'b1;
    model_load(253);
    @(posedge clk_frequency); #1;
    chk("init_load", adjusteddiv, 253);
    measure("slow1", cyc);
    measure("slow2", cyc);

    // Sustained in-window period reaches lock, then stays locked
    per = 120;
    gen_req++;
    for (int i = 0; i < SETTLE; i++) measure($sformatf("lock%0d", i), cyc);
    measure("lock_hold", cyc);

    // Period drops below fmax while locked
    per = 50;
    gen_req++;
    measure("fast_unlock", cyc);

    // Empty window: too-slow test has priority
    fmin = 8'd100;
    fmax = 8'd150;
    per  = 120;
    gen_req++;
    measure("empty_slow", cyc);
    per = 80;
    gen_req++;
    measure("empty_fast", cyc);

    // Randomized periods and windows
    for (int i = 0; i < 10; i++) begin
      per  = int'($urandom_range(250, 20));
      fmin = 8'($urandom_range(220, 60));
      fmax = 8'($urandom_range(200, 40));
      gen_req++;
      measure($sformatf("rand%0d", i), cyc);
    end

    // Top clamp: 254 -> 255, then blocked with sat, then cleared in-window
    init = 1'b0;
    @(posedge clk_frequency); #1;
    m_locked = 1'b0;
    chk("init_drop.locked", locked, 0);
    setperiod = 8'd254;
    fmin      = 8'd200;
    fmax      = 8'd90;
    per       = 50;
    gen_req++;
    init = 1'b1;
    model_load(254);
    @(posedge clk_frequency); #1;
    chk("sat_hi.load", adjusteddiv, 254);
    measure("sat_hi_a", cyc);
    measure("sat_hi_b", cyc);
    per = 120;
    gen_req++;
    measure("sat_clear", cyc);

    // init dropped while a measurement is in flight
    repeat (150) @(posedge clk_frequency);
    #1 init = 1'b0;
    held = m_div;
    m_locked = 1'b0;
    @(posedge clk_frequency); #1;
    chk("mid_idle.locked", locked, 0);
    chk("mid_idle.div", adjusteddiv, held);
    chk("mid_idle.inc", increment, 0);
    chk("mid_idle.dec", decrement, 0);
    snap = co_seen;
    repeat (400) @(posedge clk_frequency);
    #1;
    chk("idle.no_co", co_seen - snap, 0);
    chk("idle.div_held", adjusteddiv, held);

    // Dead ring: timeouts walk the divider down to 0, then clamp
    setperiod = 8'd3;
    fmin      = 8'd160;
    fmax      = 8'd90;
    per       = 0;
    gen_req++;
    init = 1'b1;
    model_load(3);
    @(posedge clk_frequency); #1;
    chk("stuck.load", adjusteddiv, 3);
    measure("stuck0", cyc);
    for (int i = 1; i < 5; i++) begin
      measure($sformatf("stuck%0d", i), cyc);
      chk($sformatf("stuck%0d.interval_ge256", i), (cyc + 1 >= 256), 1);
    end

    // Asynchronous reset while DECIDE is active
    cyc = 0;
    do begin
      @(posedge clk_frequency); #1;
      cyc++;
    end while (co !== 1'b1 && cyc < 600);
    chk("rst_decide.co", co, 1);
    rst_frequency = 1'b1;
    #1;
    chk_all_zero("rst_decide");
    init     = 1'b0;
    m_div    = 0;
    m_fs     = 0;
    m_sat    = 1'b0;
    m_locked = 1'b0;
    m_lcnt   = 0;
    per      = 120;
    gen_req++;
    repeat (3) @(posedge clk_frequency);
    #1 rst_frequency = 1'b0;
    @(posedge clk_frequency); #1;
    setperiod = 8'd100;
    init      = 1'b1;
    model_load(100);
    @(posedge clk_frequency); #1;
    chk("post_rst.load", adjusteddiv, 100);
    measure("post_rst", cyc);

    @(negedge clk_frequency);
    @(posedge clk_frequency); #1;
    chk("total.inc", inc_seen, m_inc);
    chk("total.dec", dec_seen, m_dec);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_regulator_gen2.md
FREQ_REGULATOR_GEN2 -- requirements
Module: freq_regulator_gen2

Interface
REQ-001 Parameter W, default 8: width of the period counter, the limits, the divider setting and the step.
REQ-002 Parameter SETTLE, default 4: number of consecutive in-window decisions required for lock (range 1..15).
REQ-003 Parameter STEP, default 1: divider increment/decrement applied per adjustment (range 1..2^W-1).
REQ-004 clk_frequency  in  1  reference clock; all state is in this domain.
REQ-005 rst_frequency  in  1  asynchronous, active-high reset.
REQ-006 init  in  1  level enable; 1 = run regulation, 0 = return to IDLE.
REQ-007 ring_clk  in  1  oscillator under regulation; asynchronous to clk_frequency.
REQ-008 setperiod  in  W  initial divider value loaded when leaving IDLE.
REQ-009 fmin  in  W  upper period limit, in reference cycles (slowest allowed).
REQ-010 fmax  in  W  lower period limit, in reference cycles (fastest allowed).
REQ-011 adjusteddiv  out  W  current divider setting driven to the oscillator.
REQ-012 increment / decrement  out  1 each  one-cycle pulses marking an adjustment of adjusteddiv by +STEP / -STEP.
REQ-013 co  out  1  one-cycle pulse when a period measurement completes.
REQ-014 locked  out  1  level; regulation is within the window.
REQ-015 final_sett  out  W  adjusteddiv captured on the cycle locked rises.
REQ-016 sat  out  1  level; the last requested adjustment was blocked by 0 or 2^W-1.

Function
REQ-017 ring_clk shall pass through a 2-flop synchroniser; a rising edge is detected from the synchronised value and the previous synchronised value.
REQ-018 The state machine shall have the states IDLE, ARM, MEASURE, DECIDE and LOCKED.
REQ-019 IDLE: when init=1, load adjusteddiv<=setperiod, clear the lock counter, and go to ARM.
REQ-020 ARM: on the first detected edge, clear the period counter P and go to MEASURE.
REQ-021 MEASURE: increment P each cycle; on the next edge, pulse co and go to DECIDE with the final P value.
REQ-022 P shall saturate at 2^W-1 with no wrap; saturation shall force the transition to DECIDE with a co pulse (timeout, treated as too slow).
REQ-023 DECIDE is one cycle: if P>fmin (too slow), adjusteddiv -= STEP and pulse decrement; if P<fmax (too fast), adjusteddiv += STEP and pulse increment; otherwise the lock counter increments.
REQ-024 Any adjustment shall clear the lock counter; when the lock counter reaches SETTLE, assert locked, capture final_sett and enter LOCKED, otherwise return to ARM.
REQ-025 LOCKED: keep measuring as in ARM/MEASURE; the first out-of-window decision drops locked in the same cycle, applies the adjustment and resumes at ARM.
REQ-026 The add and subtract shall be W+1-bit and clamp at 2^W-1 and 0; a clamped request changes nothing, produces no inc/dec pulse and sets sat; the next unclamped decision clears sat.
REQ-027 If fmax>fmin (empty window), every decision shall be out-of-window; the too-slow test is evaluated first.
REQ-028 init=0 in any state shall return the FSM to IDLE on the next edge and clear locked; adjusteddiv and final_sett hold their values.
REQ-029 Latency: co follows the terminating synchronised edge by one cycle, and inc/dec/adjusteddiv update one cycle after co.

Reset
REQ-030 rst_frequency=1 shall immediately force IDLE and clear adjusteddiv, final_sett, P, the lock counter, co, increment, decrement, locked, sat and the synchroniser to 0.
REQ-031 Reset release is synchronous in effect: the first evaluation happens on the first clk_frequency edge after deassertion.

Configuration
REQ-032 Macro FREQREG_AVG_EN defined: DECIDE shall compare the mean of 4 consecutive P values (sum >> 2, W+2-bit accumulator) and co pulses every measurement, but a decision occurs only every 4th; a timeout shall abort the group and decide immediately as too slow.
REQ-033 Macro FREQREG_AVG_EN undefined: each single P shall be decided; no accumulator logic shall be present.

Verification
REQ-034 Reset held, then init=1, setperiod=253 -> adjusteddiv=253 one cycle after init.
REQ-035 ring period 200 ref cycles, fmin=160, fmax=90 -> decrement pulse, adjusteddiv 253->252 after the first co.
REQ-036 ring period 120 sustained, SETTLE=4 -> locked rises after the 4th co, final_sett = adjusteddiv, no inc/dec pulses.
REQ-037 ring_clk stuck low, W=8 -> co at P=255, decrement every 256+ cycles until adjusteddiv=0, then sat=1 with no further pulses.
REQ-038 Locked, then the period drops to 50 -> locked falls at DECIDE, increment pulses, adjusteddiv +1.
REQ-039 init dropped mid-MEASURE, and separately rst_frequency asserted mid-DECIDE -> IDLE next edge with the value held / all outputs 0 asynchronously.
